// File: rtl/ray_dispatch_pkg.sv
// ray_dispatch_pkg: shared types for the ray dispatcher.
// Holds the frame FSM encoding, the per-core pixel tag and a saturating helper.
// Tag fields are sized for the largest supported display; users size-cast.
package ray_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dispatch_state_t;

  localparam int TAG_BITS = 16;

  typedef struct packed {
    logic [TAG_BITS-1:0] hcount;
    logic [TAG_BITS-1:0] vcount;
  } pixel_tag_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: one-hot grant over N requests, search starts at pointer.
// Latency: grant is combinational; pointer moves to grant+1 mod N on the next edge.
// Backpressure: none; a grant is always consumed in the cycle it is produced.
// Ports: clk_in/rst_in (async active-high), req_in, grant_out (one-hot), grant_valid_out.
module round_robin_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] grant_out,
  output logic         grant_valid_out
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Two passes: indices at/above the pointer first, then the wrapped-around ones.
  always_comb begin
    grant_out = '0;
    found     = 1'b0;
    ptr_d     = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!found && req_in[i] && (i >= int'(ptr_q))) begin
        grant_out[i] = 1'b1;
        found        = 1'b1;
        ptr_d        = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_in[i] && (i < int'(ptr_q))) begin
        grant_out[i] = 1'b1;
        found        = 1'b1;
        ptr_d        = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  assign grant_valid_out = found;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ray_dispatcher.sv
// ray_dispatcher: raster-order pixel issue to NUM_CORES ray cores, round-robin
// result collection, single framebuffer write stream. All outputs registered (1 cycle).
// Backpressure: none on the write stream; issue stalls while every core is busy.
// Optional: define RAY_DISPATCH_CYCLES_EN for the frame render-time counter.
// Ports: frame control (frame_start_in, fractal_sel_in, busy_out, frame_done_out,
// frame_cycles_out), core issue (core_valid/hcount/vcount/fractal_sel_out),
// core results (core_done_in, core_color_in, core_ack_out), pixel write (pixel_*_out).
module ray_dispatcher
  import ray_dispatch_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 8,
  parameter int COLOR_BITS     = 4,
  parameter int ADDR_BITS      = 17
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            frame_start_in,
  input  logic [2:0]                      fractal_sel_in,
  output logic [NUM_CORES-1:0]            core_valid_out,
  output logic [H_BITS-1:0]               core_hcount_out,
  output logic [V_BITS-1:0]               core_vcount_out,
  output logic [2:0]                      core_fractal_sel_out,
  input  logic [NUM_CORES-1:0]            core_done_in,
  input  logic [NUM_CORES*COLOR_BITS-1:0] core_color_in,
  output logic [NUM_CORES-1:0]            core_ack_out,
  output logic                            pixel_valid_out,
  output logic [H_BITS-1:0]               pixel_hcount_out,
  output logic [V_BITS-1:0]               pixel_vcount_out,
  output logic [ADDR_BITS-1:0]            pixel_addr_out,
  output logic [COLOR_BITS-1:0]           pixel_color_out,
  output logic                            busy_out,
  output logic                            frame_done_out,
  output logic [31:0]                     frame_cycles_out
);

  dispatch_state_t        state_q, state_d;
  logic [H_BITS-1:0]      scan_h_q, scan_h_d;
  logic [V_BITS-1:0]      scan_v_q, scan_v_d;
  logic [NUM_CORES-1:0]   busy_q, busy_d;
  pixel_tag_t             tag_q [NUM_CORES];
  pixel_tag_t             tag_d [NUM_CORES];
  logic [2:0]             fsel_q, fsel_d;
  logic [NUM_CORES-1:0]   core_valid_q, core_valid_d;
  logic [H_BITS-1:0]      core_h_q, core_h_d;
  logic [V_BITS-1:0]      core_v_q, core_v_d;
  logic [NUM_CORES-1:0]   core_ack_q, core_ack_d;
  logic                   pix_vld_q, pix_vld_d;
  logic [H_BITS-1:0]      pix_h_q, pix_h_d;
  logic [V_BITS-1:0]      pix_v_q, pix_v_d;
  logic [ADDR_BITS-1:0]   pix_addr_q, pix_addr_d;
  logic [COLOR_BITS-1:0]  pix_color_q, pix_color_d;
  logic                   busy_out_q, busy_out_d;
  logic                   frame_done_q, frame_done_d;

  logic [NUM_CORES-1:0]   grant;
  logic                   grant_vld;
  logic                   issue_found;
  logic                   last_pixel;
  pixel_tag_t             sel_tag;
  logic [COLOR_BITS-1:0]  sel_color;

  // Only cores holding an outstanding pixel may compete; a stale or spurious
  // done on an idle core never reaches the arbiter.
  round_robin_arbiter #(.N(NUM_CORES)) u_arb (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .req_in          (core_done_in & busy_q),
    .grant_out       (grant),
    .grant_valid_out (grant_vld)
  );

  assign last_pixel = (scan_h_q == H_BITS'(DISPLAY_WIDTH - 1)) &&
                      (scan_v_q == V_BITS'(DISPLAY_HEIGHT - 1));

  always_comb begin
    state_d      = state_q;
    scan_h_d     = scan_h_q;
    scan_v_d     = scan_v_q;
    fsel_d       = fsel_q;
    tag_d        = tag_q;
    core_valid_d = '0;
    core_h_d     = '0;
    core_v_d     = '0;
    issue_found  = 1'b0;
    sel_tag      = '0;
    sel_color    = '0;

    // Collect: grant is one-hot, so a plain select is enough.
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) begin
        sel_tag   = tag_q[i];
        sel_color = core_color_in[i*COLOR_BITS +: COLOR_BITS];
      end
    end
    busy_d      = busy_q & ~grant;
    core_ack_d  = grant;
    pix_vld_d   = grant_vld;
    pix_h_d     = H_BITS'(sel_tag.hcount);
    pix_v_d     = V_BITS'(sel_tag.vcount);
    pix_addr_d  = ADDR_BITS'(sel_tag.vcount) * ADDR_BITS'(DISPLAY_WIDTH) +
                  ADDR_BITS'(sel_tag.hcount);
    pix_color_d = sel_color;

    // Issue looks at busy_q, so a core granted this cycle is not yet free;
    // it becomes eligible next cycle.
    if (state_q == RUN) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!issue_found && !busy_q[i]) begin
          issue_found     = 1'b1;
          busy_d[i]       = 1'b1;
          tag_d[i].hcount = TAG_BITS'(scan_h_q);
          tag_d[i].vcount = TAG_BITS'(scan_v_q);
          core_valid_d[i] = 1'b1;
          core_h_d        = scan_h_q;
          core_v_d        = scan_v_q;
        end
      end
      if (issue_found) begin
        if (scan_h_q == H_BITS'(DISPLAY_WIDTH - 1)) begin
          scan_h_d = '0;
          scan_v_d = scan_v_q + V_BITS'(1);
        end else begin
          scan_h_d = scan_h_q + H_BITS'(1);
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          fsel_d   = fractal_sel_in;
          scan_h_d = '0;
          scan_v_d = '0;
          state_d  = RUN;
        end
      end
      RUN:     if (issue_found && last_pixel) state_d = DRAIN;
      DRAIN:   if (busy_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_out_d   = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      scan_h_q     <= '0;
      scan_v_q     <= '0;
      busy_q       <= '0;
      fsel_q       <= '0;
      for (int i = 0; i < NUM_CORES; i++) tag_q[i] <= '0;
      core_valid_q <= '0;
      core_h_q     <= '0;
      core_v_q     <= '0;
      core_ack_q   <= '0;
      pix_vld_q    <= 1'b0;
      pix_h_q      <= '0;
      pix_v_q      <= '0;
      pix_addr_q   <= '0;
      pix_color_q  <= '0;
      busy_out_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_h_q     <= scan_h_d;
      scan_v_q     <= scan_v_d;
      busy_q       <= busy_d;
      fsel_q       <= fsel_d;
      tag_q        <= tag_d;
      core_valid_q <= core_valid_d;
      core_h_q     <= core_h_d;
      core_v_q     <= core_v_d;
      core_ack_q   <= core_ack_d;
      pix_vld_q    <= pix_vld_d;
      pix_h_q      <= pix_h_d;
      pix_v_q      <= pix_v_d;
      pix_addr_q   <= pix_addr_d;
      pix_color_q  <= pix_color_d;
      busy_out_q   <= busy_out_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef RAY_DISPATCH_CYCLES_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] fcyc_q, fcyc_d;

  // The copy taken in DONE already includes the DONE cycle itself.
  always_comb begin
    cyc_d  = cyc_q;
    fcyc_d = fcyc_q;
    if (state_q == IDLE) begin
      if (frame_start_in) cyc_d = '0;
    end else begin
      cyc_d = sat_inc32(cyc_q);
    end
    if (state_q == DONE) fcyc_d = cyc_d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cyc_q  <= '0;
      fcyc_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      fcyc_q <= fcyc_d;
    end
  end

  assign frame_cycles_out = fcyc_q;
`else
  assign frame_cycles_out = 32'd0;
`endif

  assign core_valid_out       = core_valid_q;
  assign core_hcount_out      = core_h_q;
  assign core_vcount_out      = core_v_q;
  assign core_fractal_sel_out = fsel_q;
  assign core_ack_out         = core_ack_q;
  assign pixel_valid_out      = pix_vld_q;
  assign pixel_hcount_out     = pix_h_q;
  assign pixel_vcount_out     = pix_v_q;
  assign pixel_addr_out       = pix_addr_q;
  assign pixel_color_out      = pix_color_q;
  assign busy_out             = busy_out_q;
  assign frame_done_out       = frame_done_q;

endmodule
